axis_ram_rw: RTL and testbench
==============================

Name: axis_ram_rw

Overview:
- Parametrised AXI-Stream RAM with in-band write and read commands, auto-incrementing bursts, and an AXI-Stream read-response master with full backpressure.
- Supersedes the fixed 32-bit write-only stream RAM.
- Used as scratch/shared memory between stream producers and consumers in the core's AXI fabric.

Parameters:
- DATA_W, 32, width of data beats and of each memory word.
- ADDR_W, 8, word address width; memory depth = 2**ADDR_W words.
- RESP_DEPTH, 4, read-response buffer entries; power of two, minimum 2.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  DATA_W  write data; ignored on read beats.
- s_axis_tuser  in  ADDR_W+1  command: [ADDR_W] = 1 write / 0 read; [ADDR_W-1:0] = start address. Sampled on the first beat of a packet only.
- s_axis_tlast  in  1  last beat of the command packet.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tready  out  1  slave ready.
- m_axis_tdata  out  DATA_W  read data.
- m_axis_tlast  out  1  copy of s_axis_tlast of the read beat that produced this response.
- m_axis_tvalid  out  1  master valid.
- m_axis_tready  in  1  master ready.

Behaviour:
- Reset:
  - Asserting aresetn low at any time immediately clears all state: FSM to IDLE, response buffer emptied, in-flight read dropped.
  - Output values during reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready rises on the first aclk edge after deassertion.
  - Memory array is not cleared. Contents survive reset and are undefined at power-up.
  - A reset mid-packet discards the rest of that packet. The next accepted beat is treated as a first beat.
- Beat acceptance: a beat is accepted when s_axis_tvalid && s_axis_tready at a rising edge.
- FSM:
  - IDLE: an accepted beat latches op=tuser[ADDR_W] and addr=tuser[ADDR_W-1:0], then executes. If tlast=0, go to BURST; if tlast=1, stay in IDLE.
  - BURST: an accepted beat executes with the latched op and ptr. tuser is ignored. tlast=1 returns to IDLE.
  - After every executed beat, ptr = ptr+1 modulo 2**ADDR_W; it wraps from all-ones to 0 silently.
- Write beat: mem[ptr] <= tdata at the accept edge. Never generates a response.
- Read beat:
  - The registered memory read issues at the accept edge. Data is pushed into the response buffer at the next edge (one cycle in flight).
  - The response reaches the master interface no earlier than 2 cycles after acceptance.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data. No hazard window.
- Response buffer:
  - FIFO of RESP_DEPTH entries of {tdata, tlast}. The head drives m_axis_*.
  - m_axis_tvalid = buffer not empty.
  - Pop when m_axis_tvalid && m_axis_tready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Master outputs hold stable while tvalid=1 and tready=0.
- Flow control:
  - s_axis_tready is registered from state only. It never depends on the current tvalid, tuser or op.
  - s_axis_tready = (occupancy_next + inflight_next) < RESP_DEPTH, where occupancy_next and inflight_next are the post-edge values.
  - The buffer therefore never overflows, and writes are also stalled while this condition is false.
  - With m_axis_tready held high, read bursts sustain 1 beat/cycle.
- Ordering: responses leave in acceptance order. A response keeps its order even when writes are interleaved between reads.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles with tvalid=1 -> s_axis_tready=0, m_axis_tvalid=0, no memory write; tready=1 on the first edge after release.
- Single write then read: write 0xDEADBEEF to addr 0x10 (tuser=0x110, tlast=1), next cycle read addr 0x10 (tuser=0x010) -> m_axis_tdata=0xDEADBEEF, tlast=1, tvalid exactly 2 cycles after the read accept.
- Wrapping burst: write a 4-beat burst at 0xFE with data 1,2,3,4, then a 4-beat read at 0xFE -> response data 1,2,3,4, with addresses 0xFE,0xFF,0x00,0x01 used; tlast only on beat 4.
- Backpressure: 8-beat read with m_axis_tready=0 -> s_axis_tready drops after 4 accepted beats (RESP_DEPTH=4). m_axis_tdata stays stable while stalled. Releasing tready delivers all 8 in order with no loss or duplicate.
- Throughput: 16-beat read with m_axis_tready=1 throughout -> 16 consecutive accepts and 16 consecutive response beats, no bubbles after the initial 2-cycle latency.
- Reset mid-burst: assert aresetn low after beat 2 of a 5-beat read with responses pending -> m_axis_tvalid=0 immediately. After release, a new packet uses its own tuser address. Memory written before the reset still reads back intact.

Source files
------------

// File: rtl/axis_ram_rw_if.sv
// AXI-Stream bundle shared by the command slave and the read-response master of axis_ram_rw.
`timescale 1ns/1ps
interface axis_ram_rw_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 9
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_ram_rw.sv
// Stream-commanded RAM: packets carry write data or read requests with auto-incrementing
// addresses; reads return through a small response FIFO with full master backpressure.
`timescale 1ns/1ps
module axis_ram_rw #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int RESP_DEPTH = 4
) (
    input  logic          aclk,
    input  logic          aresetn,
    axis_ram_rw_if.slave  s_axis,
    axis_ram_rw_if.master m_axis
);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e            state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              s_ready_q, s_ready_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_last_q;
    logic [DATA_W-1:0] fifo_data_q [RESP_DEPTH];
    logic              fifo_last_q [RESP_DEPTH];

    logic              accept, beat_wr, wr_en, rd_en, push, pop;
    logic [ADDR_W-1:0] beat_addr;

    // The first beat of a packet takes op and address from tuser; later beats use latched state.
    always_comb begin
        accept    = s_axis.tvalid && s_ready_q;
        beat_wr   = (state_q == ST_IDLE) ? s_axis.tuser[ADDR_W] : op_wr_q;
        beat_addr = (state_q == ST_IDLE) ? s_axis.tuser[ADDR_W-1:0] : ptr_q;
        wr_en     = accept && beat_wr;
        rd_en     = accept && !beat_wr;
        push      = inflight_q;
        pop       = (count_q != '0) && m_axis.tready;
    end

    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        ptr_d      = ptr_q;
        inflight_d = rd_en;
        if (accept) begin
            op_wr_d = beat_wr;
            ptr_d   = beat_addr + ADDR_W'(1);
            state_d = s_axis.tlast ? ST_IDLE : ST_BURST;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        tail_d = push ? tail_q + PTR_W'(1) : tail_q;
        head_d = pop  ? head_q + PTR_W'(1) : head_q;

        // Reserve a slot for the read still in flight so the FIFO can never overflow.
        s_ready_d = (count_d + CNT_W'(inflight_d)) < DEPTH_C;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            op_wr_q    <= 1'b0;
            ptr_q      <= '0;
            s_ready_q  <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            ptr_q      <= ptr_d;
            s_ready_q  <= s_ready_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push) begin
                fifo_data_q[tail_q] <= rd_data_q;
                fifo_last_q[tail_q] <= rd_last_q;
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block memory; contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[beat_addr] <= s_axis.tdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[beat_addr];
            rd_last_q <= s_axis.tlast;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = (count_q != '0);
    assign m_axis.tdata  = fifo_data_q[head_q];
    assign m_axis.tlast  = fifo_last_q[head_q];
    assign m_axis.tuser  = '0;
endmodule

// File: tb/tb_axis_ram_rw.sv
// Directed bench for axis_ram_rw: reset, single and wrapping bursts, ordering,
// backpressure, throughput and reset in the middle of a read burst.
`timescale 1ns/1ps
module tb_axis_ram_rw;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int RESP_DEPTH = 4;
    localparam int USER_W     = ADDR_W + 1;
    localparam int BOUND      = 50;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                cyc;
    } resp_t;
    resp_t rq[$];

    axis_ram_rw_if #(.DATA_W(DATA_W), .USER_W(USER_W)) s_if ();
    axis_ram_rw_if #(.DATA_W(DATA_W), .USER_W(USER_W)) m_if ();

    axis_ram_rw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESP_DEPTH(RESP_DEPTH)) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Record each response beat with the cycle number of the edge that pops it.
    always @(negedge aclk) begin
        if (aresetn && m_if.tvalid && m_if.tready) begin
            resp_t r;
            r.data = m_if.tdata;
            r.last = m_if.tlast;
            r.cyc  = cyc + 1;
            rq.push_back(r);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [USER_W-1:0] u, input logic l);
        int w = 0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        while (!s_if.tready && w < BOUND) begin
            step(1);
            w++;
        end
        if (!s_if.tready) begin
            n_checks++;
            $display("FAIL send_timeout: s_axis_tready=%0b after %0d cycles, required 1", s_if.tready, w);
        end else begin
            step(1);
            acc_cyc = cyc;
        end
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] base, input int n);
        logic [USER_W-1:0] u0;
        u0 = {1'b1, addr};
        for (int i = 0; i < n; i++) begin
            send_beat(base + DATA_W'(i), (i == 0) ? u0 : ~u0, i == n - 1);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] addr, input int n);
        logic [USER_W-1:0] u0;
        u0 = {1'b0, addr};
        for (int i = 0; i < n; i++) begin
            send_beat('0, (i == 0) ? u0 : ~u0, i == n - 1);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_resps(input int n);
        int w = 0;
        while (rq.size() < n && w < BOUND) begin
            step(1);
            w++;
        end
        if (rq.size() < n) begin
            n_checks++;
            $display("FAIL resp_timeout: got %0d responses, required %0d", rq.size(), n);
        end
    endtask

    task automatic test_reset();
        write_burst(8'h20, 32'h1111_1111, 1);
        step(1);
        aresetn     = 1'b0;
        s_if.tdata  = 32'hBAD0_BAD0;
        s_if.tuser  = 9'h120;
        s_if.tlast  = 1'b1;
        s_if.tvalid = 1'b1;
        #1;
        n_checks++;
        if ({s_if.tready, m_if.tvalid, m_if.tlast} !== 3'b000 || m_if.tdata !== 32'h0) begin
            $display("FAIL reset_outputs: tready=%0b tvalid=%0b tlast=%0b tdata=%h, required all 0",
                     s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata);
        end else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_checks++;
            if ({s_if.tready, m_if.tvalid} !== 2'b00) begin
                $display("FAIL reset_hold_%0d: tready=%0b tvalid=%0b, required 0 0", i, s_if.tready, m_if.tvalid);
            end else n_pass++;
        end
        s_if.tvalid = 1'b0;
        aresetn     = 1'b1;
        #1;
        n_checks++;
        if (s_if.tready !== 1'b0) begin
            $display("FAIL reset_release_noedge: tready=%0b, required 0", s_if.tready);
        end else n_pass++;
        step(1);
        n_checks++;
        if (s_if.tready !== 1'b1) begin
            $display("FAIL reset_release_edge: tready=%0b, required 1", s_if.tready);
        end else n_pass++;
        rq.delete();
        read_burst(8'h20, 1);
        wait_resps(1);
        n_checks++;
        if (rq.size() < 1 || rq[0].data !== 32'h1111_1111) begin
            $display("FAIL reset_no_write: data=%h, required 11111111", (rq.size() > 0) ? rq[0].data : 'x);
        end else n_pass++;
    endtask

    task automatic test_single_rw();
        int rd_acc;
        rq.delete();
        send_beat(32'hDEAD_BEEF, 9'h110, 1'b1);
        send_beat(32'h0, 9'h010, 1'b1);
        s_if.tvalid = 1'b0;
        rd_acc = acc_cyc;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin
            $display("FAIL single_early_valid: tvalid=%0b one cycle after accept, required 0", m_if.tvalid);
        end else n_pass++;
        step(1);
        n_checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'hDEAD_BEEF || m_if.tlast !== 1'b1) begin
            $display("FAIL single_resp: tvalid=%0b tdata=%h tlast=%0b, required 1 deadbeef 1",
                     m_if.tvalid, m_if.tdata, m_if.tlast);
        end else n_pass++;
        wait_resps(1);
        n_checks++;
        if (rq.size() < 1 || rq[0].cyc - rd_acc != 2) begin
            $display("FAIL single_latency: handshake %0d cycles after accept, required 2",
                     (rq.size() > 0) ? rq[0].cyc - rd_acc : -1);
        end else n_pass++;
    endtask

    task automatic test_wrap_burst();
        logic [ADDR_W-1:0] addrs [3];
        logic [DATA_W-1:0] exps  [3];
        addrs = '{8'hFF, 8'h00, 8'h01};
        exps  = '{32'd2, 32'd3, 32'd4};
        write_burst(8'hFE, 32'd1, 4);
        rq.delete();
        read_burst(8'hFE, 4);
        wait_resps(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rq.size() <= i || rq[i].data !== DATA_W'(i + 1) || rq[i].last !== (i == 3)) begin
                $display("FAIL wrap_beat_%0d: data=%h last=%0b, required %h %0b", i,
                         (rq.size() > i) ? rq[i].data : 'x, (rq.size() > i) ? rq[i].last : 1'bx, i + 1, i == 3);
            end else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            rq.delete();
            read_burst(addrs[i], 1);
            wait_resps(1);
            n_checks++;
            if (rq.size() < 1 || rq[0].data !== exps[i]) begin
                $display("FAIL wrap_addr_%h: data=%h, required %h", addrs[i],
                         (rq.size() > 0) ? rq[0].data : 'x, exps[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_interleave();
        rq.delete();
        send_beat(32'h5A5A_0001, 9'h150, 1'b1);
        send_beat(32'h0,         9'h050, 1'b1);
        send_beat(32'h5A5A_0002, 9'h150, 1'b1);
        send_beat(32'h0,         9'h050, 1'b1);
        s_if.tvalid = 1'b0;
        wait_resps(2);
        n_checks++;
        if (rq.size() < 2 || rq[0].data !== 32'h5A5A_0001 || rq[1].data !== 32'h5A5A_0002) begin
            $display("FAIL interleave_order: data=%h,%h, required 5a5a0001,5a5a0002",
                     (rq.size() > 0) ? rq[0].data : 'x, (rq.size() > 1) ? rq[1].data : 'x);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [USER_W-1:0] u0;
        int bad = 0;
        u0 = {1'b0, 8'h40};
        write_burst(8'h40, 32'hA0, 8);
        rq.delete();
        m_if.tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat('0, (i == 0) ? u0 : ~u0, 1'b0);
        n_checks++;
        if (s_if.tready !== 1'b0) begin
            $display("FAIL bp_ready_drop: tready=%0b after 4 accepts, required 0", s_if.tready);
        end else n_pass++;
        s_if.tuser  = ~u0;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b1 || m_if.tdata !== 32'hA0 || m_if.tlast !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL bp_stall_stable: %0d unstable cycles, required 0 (tready=%0b tvalid=%0b tdata=%h)",
                     bad, s_if.tready, m_if.tvalid, m_if.tdata);
        end else n_pass++;
        m_if.tready = 1'b1;
        for (int i = 4; i < 8; i++) send_beat('0, ~u0, i == 7);
        s_if.tvalid = 1'b0;
        wait_resps(8);
        step(5);
        n_checks++;
        if (rq.size() != 8) begin
            $display("FAIL bp_count: %0d responses, required 8", rq.size());
        end else n_pass++;
        for (int i = 0; i < 8 && i < rq.size(); i++) begin
            n_checks++;
            if (rq[i].data !== DATA_W'(32'hA0 + i) || rq[i].last !== (i == 7)) begin
                $display("FAIL bp_beat_%0d: data=%h last=%0b, required %h %0b",
                         i, rq[i].data, rq[i].last, 32'hA0 + i, i == 7);
            end else n_pass++;
        end
    endtask

    task automatic test_throughput();
        int acc [16];
        int gaps = 0;
        int bubbles = 0;
        logic [USER_W-1:0] u0;
        u0 = {1'b0, 8'h80};
        write_burst(8'h80, 32'h1000, 16);
        rq.delete();
        for (int i = 0; i < 16; i++) begin
            send_beat('0, (i == 0) ? u0 : ~u0, i == 15);
            acc[i] = acc_cyc;
        end
        s_if.tvalid = 1'b0;
        wait_resps(16);
        step(3);
        for (int i = 1; i < 16; i++) if (acc[i] != acc[0] + i) gaps++;
        n_checks++;
        if (gaps != 0) begin
            $display("FAIL tp_accepts: %0d gaps in accept stream, required 0", gaps);
        end else n_pass++;
        n_checks++;
        if (rq.size() != 16) begin
            $display("FAIL tp_count: %0d responses, required 16", rq.size());
        end else n_pass++;
        for (int i = 0; i < 16 && i < rq.size(); i++) begin
            if (rq[i].cyc != acc[0] + 2 + i) bubbles++;
            n_checks++;
            if (rq[i].data !== DATA_W'(32'h1000 + i) || rq[i].last !== (i == 15)) begin
                $display("FAIL tp_beat_%0d: data=%h last=%0b, required %h %0b",
                         i, rq[i].data, rq[i].last, 32'h1000 + i, i == 15);
            end else n_pass++;
        end
        n_checks++;
        if (bubbles != 0) begin
            $display("FAIL tp_resp_timing: %0d beats off the 1/cycle schedule, required 0", bubbles);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        write_burst(8'h30, 32'h3000, 5);
        rq.delete();
        m_if.tready = 1'b0;
        send_beat('0, 9'h030, 1'b0);
        send_beat('0, 9'h1CF, 1'b0);
        n_checks++;
        if (m_if.tvalid !== 1'b1) begin
            $display("FAIL mid_pending: tvalid=%0b before reset, required 1", m_if.tvalid);
        end else n_pass++;
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || m_if.tdata !== 32'h0) begin
            $display("FAIL mid_reset_clear: tvalid=%0b tready=%0b tdata=%h, required 0 0 0",
                     m_if.tvalid, s_if.tready, m_if.tdata);
        end else n_pass++;
        step(2);
        aresetn = 1'b1;
        step(1);
        m_if.tready = 1'b1;
        read_burst(8'h82, 1);
        read_burst(8'h34, 1);
        wait_resps(2);
        step(3);
        n_checks++;
        if (rq.size() != 2 || rq[0].data !== 32'h1002 || rq[1].data !== 32'h3004) begin
            $display("FAIL mid_after_reset: n=%0d data=%h,%h, required 2 00001002,00003004", rq.size(),
                     (rq.size() > 0) ? rq[0].data : 'x, (rq.size() > 1) ? rq[1].data : 'x);
        end else n_pass++;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        aresetn     = 1'b0;
        step(3);
        aresetn = 1'b1;
        step(1);
        test_reset();
        test_single_rw();
        test_wrap_burst();
        test_interleave();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
